// File: rtl/audio_clk_gen.sv
// Phase-accumulator audio clock generator: MCLK/BCLK/LRCK with frame-aligned
// increment updates and a frame-count lock indicator.
module audio_clk_gen #(
   parameter int unsigned ACC_W       = 32,
   parameter int unsigned INC_RESET   = 32'd1939538512,
   parameter int unsigned BCLK_HALF   = 4,
   parameter int unsigned SLOT_BITS   = 32,
   parameter int unsigned LOCK_FRAMES = 4
) (
   input  logic             clkin,
   input  logic             reset,
   input  logic [ACC_W-1:0] cfg_inc,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic             enclk0,
   input  logic             enclk1,
   input  logic             enclk2,
   output logic             mclk_o,
   output logic             bclk_o,
   output logic             lrck_o,
   output logic             bclk_fall_stb,
   output logic             frame_stb,
   output logic             lock
);

   localparam int unsigned BW = $clog2(BCLK_HALF + 1);
   localparam int unsigned LW = $clog2(SLOT_BITS + 1);
   localparam int unsigned FW = $clog2(LOCK_FRAMES + 1);

   logic [ACC_W-1:0] r_acc, w_acc_nxt;
   logic [ACC_W-1:0] r_inc, w_inc_nxt;
   logic [ACC_W-1:0] r_pend_inc, w_pend_inc_nxt;
   logic             r_pend, w_pend_nxt;
   logic [BW-1:0]    r_bcnt, w_bcnt_nxt;
   logic [LW-1:0]    r_lcnt, w_lcnt_nxt;
   logic [FW-1:0]    r_fcnt, w_fcnt_nxt;
   logic             r_mclk, w_mclk_nxt;
   logic             r_bclk, w_bclk_nxt;
   logic             r_lrck, w_lrck_nxt;
   logic             r_bclk_fall_stb, w_bclk_fall_stb_nxt;
   logic             r_frame_stb, w_frame_stb_nxt;
   logic             w_lock_nxt;

   logic [ACC_W:0]   w_sum;
   logic             w_tick, w_bclk_tgl, w_bclk_fall, w_lrck_tgl, w_lrck_fall;
   logic             w_accept, w_apply;

   always_comb begin
      w_sum       = {1'b0, r_acc} + {1'b0, r_inc};
      w_tick      = w_sum[ACC_W];
      w_bclk_tgl  = w_tick && (r_bcnt == BW'(BCLK_HALF - 1));
      w_bclk_fall = w_bclk_tgl && r_bclk;
      w_lrck_tgl  = w_bclk_fall && (r_lcnt == LW'(SLOT_BITS - 1));
      w_lrck_fall = w_lrck_tgl && r_lrck;
      w_accept    = cfg_valid && !r_pend;
      // A zero increment never produces a frame, so apply without waiting for one.
      w_apply     = r_pend && (r_frame_stb || (r_inc == '0));
   end

   always_comb begin
      w_acc_nxt           = w_sum[ACC_W-1:0];
      w_inc_nxt           = r_inc;
      w_pend_nxt          = r_pend;
      w_pend_inc_nxt      = r_pend_inc;
      w_mclk_nxt          = r_mclk ^ w_tick;
      w_bcnt_nxt          = r_bcnt;
      w_bclk_nxt          = r_bclk ^ w_bclk_tgl;
      w_lcnt_nxt          = r_lcnt;
      w_lrck_nxt          = r_lrck ^ w_lrck_tgl;
      w_bclk_fall_stb_nxt = w_bclk_fall;
      w_frame_stb_nxt     = w_lrck_fall;
      w_fcnt_nxt          = r_fcnt;

      if (w_tick) begin
         w_bcnt_nxt = w_bclk_tgl ? '0 : r_bcnt + BW'(1);
      end
      if (w_bclk_fall) begin
         w_lcnt_nxt = w_lrck_tgl ? '0 : r_lcnt + LW'(1);
      end
      if (r_frame_stb && (r_fcnt != FW'(LOCK_FRAMES))) begin
         w_fcnt_nxt = r_fcnt + FW'(1);
      end

      if (w_accept) begin
         w_pend_nxt     = 1'b1;
         w_pend_inc_nxt = cfg_inc;
      end

      if (w_apply) begin
         w_inc_nxt           = r_pend_inc;
         w_pend_nxt          = 1'b0;
         w_acc_nxt           = '0;
         w_mclk_nxt          = 1'b0;
         w_bcnt_nxt          = '0;
         w_bclk_nxt          = 1'b0;
         w_lcnt_nxt          = '0;
         w_lrck_nxt          = 1'b0;
         w_bclk_fall_stb_nxt = 1'b0;
         w_frame_stb_nxt     = 1'b0;
         w_fcnt_nxt          = '0;
      end

      w_lock_nxt = (w_fcnt_nxt == FW'(LOCK_FRAMES)) && (w_inc_nxt != '0);
   end

   always_ff @(posedge clkin or posedge reset) begin
      if (reset) begin
         r_acc           <= '0;
         r_inc           <= ACC_W'(INC_RESET);
         r_pend          <= 1'b0;
         r_pend_inc      <= '0;
         r_mclk          <= 1'b0;
         r_bcnt          <= '0;
         r_bclk          <= 1'b0;
         r_lcnt          <= '0;
         r_lrck          <= 1'b0;
         r_bclk_fall_stb <= 1'b0;
         r_frame_stb     <= 1'b0;
         r_fcnt          <= '0;
         lock            <= 1'b0;
         mclk_o          <= 1'b0;
         bclk_o          <= 1'b0;
         lrck_o          <= 1'b0;
      end else begin
         r_acc           <= w_acc_nxt;
         r_inc           <= w_inc_nxt;
         r_pend          <= w_pend_nxt;
         r_pend_inc      <= w_pend_inc_nxt;
         r_mclk          <= w_mclk_nxt;
         r_bcnt          <= w_bcnt_nxt;
         r_bclk          <= w_bclk_nxt;
         r_lcnt          <= w_lcnt_nxt;
         r_lrck          <= w_lrck_nxt;
         r_bclk_fall_stb <= w_bclk_fall_stb_nxt;
         r_frame_stb     <= w_frame_stb_nxt;
         r_fcnt          <= w_fcnt_nxt;
         lock            <= w_lock_nxt;
         mclk_o          <= r_mclk & enclk0;
         bclk_o          <= r_bclk & enclk1;
         lrck_o          <= r_lrck & enclk2;
      end
   end

   assign cfg_ready     = !r_pend;
   assign bclk_fall_stb = r_bclk_fall_stb;
   assign frame_stb     = r_frame_stb;

endmodule

// File: tb/tb_audio_clk_gen.sv
// Directed self-checking bench for audio_clk_gen with small parameters
// (8-bit accumulator, BCLK_HALF=2, SLOT_BITS=4, LOCK_FRAMES=2).
module tb_audio_clk_gen;

   logic       clkin = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] cfg_inc = 8'd0;
   logic       cfg_valid = 1'b0;
   logic       cfg_ready;
   logic       enclk0 = 1'b1, enclk1 = 1'b1, enclk2 = 1'b1;
   logic       mclk_o, bclk_o, lrck_o, bclk_fall_stb, frame_stb, lock;

   int n_vec = 0;
   int n_err = 0;
   int cyc_no = 0;

   audio_clk_gen #(
      .ACC_W(8), .INC_RESET(128), .BCLK_HALF(2), .SLOT_BITS(4), .LOCK_FRAMES(2)
   ) dut (
      .clkin(clkin), .reset(reset), .cfg_inc(cfg_inc), .cfg_valid(cfg_valid),
      .cfg_ready(cfg_ready), .enclk0(enclk0), .enclk1(enclk1), .enclk2(enclk2),
      .mclk_o(mclk_o), .bclk_o(bclk_o), .lrck_o(lrck_o),
      .bclk_fall_stb(bclk_fall_stb), .frame_stb(frame_stb), .lock(lock)
   );

   always #5 clkin = ~clkin;

   task automatic step();
      @(posedge clkin);
      #1;
      cyc_no++;
   endtask

   // Returns the cycle number of the next frame_stb, or -1 if none within max cycles.
   task automatic wait_frame(input int max, output int at);
      at = -1;
      for (int i = 0; i < max; i++) begin
         if (at < 0) begin
            step();
            if (frame_stb) at = cyc_no;
         end
      end
   endtask

   // Period between two rising edges of mclk_o (0), bclk_o (1) or lrck_o (2).
   task automatic rise_period(input int sel, input int max, output int per);
      int   t0;
      logic s, prev;
      t0 = -1;
      per = -1;
      prev = (sel == 0) ? mclk_o : (sel == 1) ? bclk_o : lrck_o;
      for (int i = 0; i < max; i++) begin
         if (per < 0) begin
            step();
            s = (sel == 0) ? mclk_o : (sel == 1) ? bclk_o : lrck_o;
            if (s && !prev) begin
               if (t0 < 0) t0 = cyc_no;
               else per = cyc_no - t0;
            end
            prev = s;
         end
      end
   endtask

   task automatic send_cfg(input logic [7:0] val);
      cfg_inc = val;
      cfg_valid = 1'b1;
      step();
      cfg_valid = 1'b0;
   endtask

   task automatic test_reset();
      step();
      step();
      n_vec++;
      if ({mclk_o, bclk_o, lrck_o, bclk_fall_stb, frame_stb, lock} !== 6'b0) begin
         n_err++;
         $display("FAIL reset_outputs: got %b expected 000000",
                  {mclk_o, bclk_o, lrck_o, bclk_fall_stb, frame_stb, lock});
      end
      n_vec++;
      if (cfg_ready !== 1'b1) begin
         n_err++;
         $display("FAIL reset_cfg_ready: got %b expected 1", cfg_ready);
      end
   endtask

   task automatic test_rates();
      int f1, f2, per;
      @(negedge clkin);
      reset = 1'b0;
      cyc_no = 0;
      wait_frame(200, f1);
      n_vec++;
      if (f1 != 64) begin
         n_err++;
         $display("FAIL first_frame: got cycle %0d expected 64", f1);
      end
      wait_frame(200, f2);
      n_vec++;
      if (f2 != 128 || lock !== 1'b0) begin
         n_err++;
         $display("FAIL second_frame: got cycle %0d lock %b expected 128 lock 0", f2, lock);
      end
      step();
      n_vec++;
      if (lock !== 1'b1) begin
         n_err++;
         $display("FAIL lock_rise: got %b expected 1", lock);
      end
      rise_period(0, 100, per);
      n_vec++;
      if (per != 4) begin
         n_err++;
         $display("FAIL mclk_period: got %0d expected 4", per);
      end
      rise_period(1, 100, per);
      n_vec++;
      if (per != 8) begin
         n_err++;
         $display("FAIL bclk_period: got %0d expected 8", per);
      end
      rise_period(2, 300, per);
      n_vec++;
      if (per != 64) begin
         n_err++;
         $display("FAIL lrck_period: got %0d expected 64", per);
      end
   endtask

   task automatic test_cfg_midframe();
      int f0, fa, f1, f2, per;
      wait_frame(200, f0);
      for (int i = 0; i < 10; i++) step();
      send_cfg(8'd64);
      n_vec++;
      if (cfg_ready !== 1'b0 || lock !== 1'b1) begin
         n_err++;
         $display("FAIL cfg_pending: got ready %b lock %b expected ready 0 lock 1",
                  cfg_ready, lock);
      end
      rise_period(0, 40, per);
      n_vec++;
      if (per != 4) begin
         n_err++;
         $display("FAIL old_rate_mclk: got %0d expected 4", per);
      end
      wait_frame(200, fa);
      n_vec++;
      if (fa != f0 + 64) begin
         n_err++;
         $display("FAIL apply_frame: got cycle %0d expected %0d", fa, f0 + 64);
      end
      step();
      n_vec++;
      if (lock !== 1'b0 || cfg_ready !== 1'b1) begin
         n_err++;
         $display("FAIL after_apply: got lock %b ready %b expected lock 0 ready 1",
                  lock, cfg_ready);
      end
      step();
      n_vec++;
      if ({mclk_o, bclk_o, lrck_o} !== 3'b000) begin
         n_err++;
         $display("FAIL cleared_clocks: got %b expected 000", {mclk_o, bclk_o, lrck_o});
      end
      rise_period(0, 60, per);
      n_vec++;
      if (per != 8) begin
         n_err++;
         $display("FAIL new_rate_mclk: got %0d expected 8", per);
      end
      wait_frame(400, f1);
      wait_frame(400, f2);
      n_vec++;
      if (f1 != fa + 129 || f2 != fa + 257 || lock !== 1'b0) begin
         n_err++;
         $display("FAIL new_rate_frames: got %0d,%0d lock %b expected %0d,%0d lock 0",
                  f1, f2, lock, fa + 129, fa + 257);
      end
      step();
      n_vec++;
      if (lock !== 1'b1) begin
         n_err++;
         $display("FAIL relock: got %b expected 1", lock);
      end
   endtask

   task automatic test_zero_inc();
      int fa, fb, bad;
      wait_frame(400, fa);
      for (int i = 0; i < 5; i++) step();
      send_cfg(8'd0);
      wait_frame(400, fa);
      step();
      step();
      bad = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         if ({mclk_o, bclk_o, lrck_o, bclk_fall_stb, frame_stb, lock} !== 6'b0) bad++;
      end
      n_vec++;
      if (bad != 0) begin
         n_err++;
         $display("FAIL frozen_zero_inc: got %0d active cycles expected 0", bad);
      end
      send_cfg(8'd128);
      n_vec++;
      if (cfg_ready !== 1'b0) begin
         n_err++;
         $display("FAIL zero_inc_pending: got %b expected 0", cfg_ready);
      end
      step();
      fa = cyc_no;
      n_vec++;
      if (cfg_ready !== 1'b1) begin
         n_err++;
         $display("FAIL zero_inc_immediate_apply: got ready %b expected 1", cfg_ready);
      end
      wait_frame(200, fb);
      n_vec++;
      if (fb != fa + 64) begin
         n_err++;
         $display("FAIL restart_frame: got cycle %0d expected %0d", fb, fa + 64);
      end
   endtask

   task automatic test_enable();
      int   f, p, q, bad_b, bad_s, bad_l;
      logic exp_b, exp_l;
      wait_frame(200, f);
      p = 0;
      q = 0;
      bad_b = 0;
      bad_s = 0;
      bad_l = 0;
      for (int i = 1; i <= 80; i++) begin
         step();
         p = (p + 1) % 8;
         q = (q + 1) % 64;
         exp_b = (i >= 11 && i <= 30) ? 1'b0 : (p >= 5 || p == 0);
         exp_l = (q >= 33 || q == 0);
         if (bclk_o !== exp_b) bad_b++;
         if (bclk_fall_stb !== (p == 0)) bad_s++;
         if (lrck_o !== exp_l) bad_l++;
         enclk1 = !(i >= 10 && i < 30);
      end
      n_vec++;
      if (bad_b != 0) begin
         n_err++;
         $display("FAIL bclk_enable: got %0d wrong cycles expected 0", bad_b);
      end
      n_vec++;
      if (bad_s != 0) begin
         n_err++;
         $display("FAIL bclk_fall_stb_while_gated: got %0d wrong cycles expected 0", bad_s);
      end
      n_vec++;
      if (bad_l != 0) begin
         n_err++;
         $display("FAIL lrck_phase: got %0d wrong cycles expected 0", bad_l);
      end
   endtask

   task automatic test_back_to_back();
      int f, per, bad;
      wait_frame(200, f);
      for (int i = 0; i < 5; i++) step();
      send_cfg(8'd64);
      cfg_inc = 8'd32;
      cfg_valid = 1'b1;
      bad = 0;
      for (int i = 0; i < 3; i++) begin
         if (cfg_ready !== 1'b0) bad++;
         step();
      end
      cfg_valid = 1'b0;
      n_vec++;
      if (bad != 0) begin
         n_err++;
         $display("FAIL second_cfg_blocked: got %0d ready cycles expected 0", bad);
      end
      wait_frame(200, f);
      step();
      rise_period(0, 60, per);
      n_vec++;
      if (per != 8) begin
         n_err++;
         $display("FAIL first_cfg_only: got mclk period %0d expected 8", per);
      end
   endtask

   task automatic test_async_reset();
      int f, per;
      wait_frame(400, f);
      for (int i = 0; i < 20; i++) step();
      send_cfg(8'd32);
      for (int i = 0; i < 5; i++) step();
      @(posedge clkin);
      #3;
      reset = 1'b1;
      #1;
      n_vec++;
      if ({mclk_o, bclk_o, lrck_o, bclk_fall_stb, frame_stb, lock} !== 6'b0 ||
          cfg_ready !== 1'b1) begin
         n_err++;
         $display("FAIL async_reset: got outs %b ready %b expected 000000 ready 1",
                  {mclk_o, bclk_o, lrck_o, bclk_fall_stb, frame_stb, lock}, cfg_ready);
      end
      step();
      step();
      @(negedge clkin);
      reset = 1'b0;
      cyc_no = 0;
      wait_frame(200, f);
      n_vec++;
      if (f != 64) begin
         n_err++;
         $display("FAIL post_reset_frame: got cycle %0d expected 64", f);
      end
      step();
      rise_period(0, 60, per);
      n_vec++;
      if (per != 4 || cfg_ready !== 1'b1) begin
         n_err++;
         $display("FAIL post_reset_inc: got period %0d ready %b expected 4 ready 1",
                  per, cfg_ready);
      end
   endtask

   initial begin
      test_reset();
      test_rates();
      test_cfg_midframe();
      test_zero_inc();
      test_enable();
      test_back_to_back();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/audio_clk_gen.md
AUDIO_CLK_GEN -- requirements
Module: audio_clk_gen

Interface
REQ-001 The block SHALL have parameter ACC_W, default 32: phase-accumulator width in bits, minimum 8.
REQ-002 The block SHALL have parameter INC_RESET, default 1939538512: increment loaded at reset (44.1 kHz x 256 MCLK from 50 MHz clkin).
REQ-003 The block SHALL have parameter BCLK_HALF, default 4: ticks per BCLK half-period, minimum 1.
REQ-004 The block SHALL have parameter SLOT_BITS, default 32: BCLK periods per LRCK half-period, minimum 2.
REQ-005 The block SHALL have parameter LOCK_FRAMES, default 4: complete frames after reset or config apply before lock rises, minimum 1.
REQ-006 The block SHALL have these ports:
- clkin  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- cfg_inc  in  ACC_W  new increment.
- cfg_valid  in  1  config request.
- cfg_ready  out  1  config can be accepted.
- enclk0 / enclk1 / enclk2  in  1 each  output enables for mclk_o / bclk_o / lrck_o.
- mclk_o, bclk_o, lrck_o  out  1 each  audio clocks.
- bclk_fall_stb  out  1  one-cycle pulse when internal BCLK falls.
- frame_stb  out  1  one-cycle pulse when internal LRCK falls (frame start).
- lock  out  1  clocks stable at current increment.

Function
REQ-007 The block SHALL update a registered accumulator each cycle as acc <= (acc + inc) mod 2^ACC_W; a carry out of bit ACC_W-1 SHALL be a "tick" for that cycle.
REQ-008 The block SHALL toggle internal MCLK on the cycle after each tick, so that f_mclk = f_clkin*inc/2^(ACC_W+1).
REQ-009 The block SHALL count ticks and toggle internal BCLK after every BCLK_HALF ticks, with a wrap-around counter width of $clog2(BCLK_HALF+1).
REQ-010 The block SHALL count BCLK falling edges and toggle internal LRCK on the falling edge that completes SLOT_BITS BCLK periods; LRCK=0 SHALL denote the left slot.
REQ-011 The block SHALL assert bclk_fall_stb for exactly the cycle on which internal BCLK goes 1->0.
REQ-012 The block SHALL assert frame_stb for exactly the cycle on which internal LRCK goes 1->0.
REQ-013 The block SHALL register mclk_o/bclk_o/lrck_o as (internal clock AND enableN).
- Deasserting enableN SHALL force that output to 0 on the next cycle without stopping internal counters or strobes.
- Reasserting enableN SHALL resume the output at its current internal phase.
REQ-014 The block SHALL assert cfg_ready whenever no config is pending, and accept a config when cfg_valid && cfg_ready, latching cfg_inc into a pending register.
REQ-015 The block SHALL hold cfg_ready low while a config is pending; cfg_valid SHALL be ignored during that time.
REQ-016 The block SHALL apply a pending config on the next frame_stb cycle, or on the cycle after acceptance if the current inc is 0.
- Apply SHALL load inc and clear acc, all divider counters, internal MCLK/BCLK/LRCK and the lock frame counter.
- Apply SHALL drop lock on that same edge and raise cfg_ready on the next cycle.
REQ-017 The block SHALL count frame_stb pulses, saturating at LOCK_FRAMES, and assert lock on the cycle after the count reaches LOCK_FRAMES.
REQ-018 The block SHALL hold lock at 0 while inc = 0; with inc = 0 there are no ticks and all internal clocks SHALL stay frozen.
REQ-019 On a frame_stb that coincides with acceptance of a config, the block SHALL take the new config as pending and apply it at the following frame_stb.

Reset
REQ-020 While reset is high, the block SHALL hold acc=0, inc=INC_RESET, all counters=0, internal and output clocks=0, strobes=0, lock=0, no pending config and cfg_ready=1.
REQ-021 The block SHALL apply reset asynchronously, and a reset during a pending config or mid-frame SHALL discard all state and restart from the REQ-020 values.

Verification (ACC_W=8, INC_RESET=128, BCLK_HALF=2, SLOT_BITS=4, LOCK_FRAMES=2, enables high)
REQ-022 The bench SHALL release reset and check:
- tick every 2 cycles, so mclk_o period is 4 cycles, bclk_o period 8 cycles, lrck_o period 64 cycles;
- first frame_stb 64 cycles after reset release;
- lock high one cycle after the second frame_stb.
REQ-023 The bench SHALL pulse cfg_valid with cfg_inc=64 mid-frame and check:
- cfg_ready goes low;
- the old rate continues until the next frame_stb, when lock drops and counters clear;
- mclk_o period then becomes 8 cycles and cfg_ready returns one cycle after apply;
- lock returns after 2 frames at the new rate.
REQ-024 The bench SHALL apply cfg_inc=0 and check outputs frozen at 0 with lock low, then apply cfg_inc=128 and check it is applied on the cycle after acceptance without waiting for a frame_stb.
REQ-025 The bench SHALL deassert enclk1 for 20 cycles and check bclk_o=0 while bclk_fall_stb keeps pulsing every 8 cycles, and that on re-enable bclk_o is in phase with an unchanged lrck_o.
REQ-026 The bench SHALL send a second cfg_valid while a config is pending and check it is not accepted (cfg_ready=0) and that only the first cfg_inc is applied.
REQ-027 The bench SHALL assert reset asynchronously between clkin edges mid-frame with a config pending and check all outputs 0, cfg_ready=1 immediately, and inc=128 after release.
